// File: rtl/div_pkg.sv
// div_pkg: shared width default and controller state encoding for the sequential divider
package div_pkg;
  localparam int DIV_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub17.sv
// sub17: combinational subtractor returning a-b and a borrow flag
module sub17
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);
  logic [W:0] w_sum;
  assign w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (W+1)'(1);
  assign o_diff   = w_sum[W-1:0];
  assign o_borrow = ~w_sum[W];
endmodule

// File: rtl/seq_divider16.sv
// seq_divider16: unsigned restoring divider, one quotient bit per clock, MSB first
module seq_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  state_t           r_state, w_next;
  logic [3:0]       r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_div_zero;
  logic [WIDTH:0]   w_shift, w_diff, w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_borrow, w_accept, w_last;

  assign w_shift   = (r_rem << 1) | (WIDTH+1)'(r_q[WIDTH-1]);
  assign w_rem_nxt = w_borrow ? w_shift : w_diff;
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};

  sub17 #(.W(WIDTH+1)) u_sub (
    .i_a     (w_shift),
    .i_b     ({1'b0, r_d}),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );

  // next state: accept in IDLE, 16 iterations in RUN, single-cycle DONE
  always_comb begin
    ready    = r_state == IDLE;
    done     = r_state == DONE;
    w_accept = ready && start;
    w_last   = r_state == RUN && r_cnt == 4'(WIDTH-1);
    w_next   = r_state == DONE ? IDLE :
               w_last          ? DONE :
               !w_accept       ? r_state :
               divisor == '0   ? DONE : RUN;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // datapath: capture operands, iterate, publish results on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_q   <= dividend;
      r_d   <= divisor;
      if (divisor == '0) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_div_zero  <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt + 4'd1;
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      if (w_last) begin
        r_quotient  <= w_q_nxt;
        r_remainder <= w_rem_nxt[WIDTH-1:0];
        r_div_zero  <= 1'b0;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
endmodule
